// File: rtl/serial_bus_pkg.sv
// Shared types for the two-master serial bus arbiter.
// No logic; latency and backpressure not applicable.
// Holds the state encoding, master ids and watchdog width helper.
package serial_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        OWNED = 2'd2
    } arb_state_t;

    typedef enum logic {
        M1 = 1'b0,
        M2 = 1'b1
    } master_id_t;

    localparam logic [1:0] SLAVE_SEL_INVALID = 2'd3;

    // Watchdog counter is at least 8 bits wide, wider for long timeouts.
    function automatic int wd_width(input int t);
        return ($clog2(t + 1) > 8) ? $clog2(t + 1) : 8;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Saturating ownership watchdog: expire is high while the count reaches TIMEOUT_CYCLES-1.
// Latency: expire asserts combinationally in the TIMEOUT_CYCLES-th enabled cycle.
// No backpressure; clr has priority over en.
module arb_watchdog
    import serial_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = wd_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAX  = '1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q >= LAST);

endmodule

// File: rtl/split_arbiter.sv
// Two-master bus arbiter with split-transaction parking and a watchdog; ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: request to arb_busy 1 cycle, to grant 2 cycles; release on the edge sampling tx_done/split/timeout.
// Backpressure: requests are levels held until grant; ineligible requests simply wait.
module split_arbiter
    import serial_bus_pkg::*;
#(
    parameter int SLAVE_LEN      = 2,
    parameter int NUM_SLAVES     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m1_req,
    input  logic                  m2_req,
    input  logic [SLAVE_LEN-1:0]  m1_slave_sel,
    input  logic [SLAVE_LEN-1:0]  m2_slave_sel,
    input  logic                  tx_done,
    input  logic [NUM_SLAVES-1:0] s_split_en,
    output logic                  m1_grant,
    output logic                  m2_grant,
    output logic                  arb_busy,
    output logic                  bus_busy,
    output logic                  bus_owner,
    output logic [SLAVE_LEN-1:0]  bus_sel,
    output logic                  split_pending,
    output logic                  sel_err,
    output logic                  timeout
);

    localparam logic [SLAVE_LEN-1:0] SEL_INV = SLAVE_LEN'(SLAVE_SEL_INVALID);

    arb_state_t            state_q, state_d;
    master_id_t            cand_owner_q, cand_owner_d;
    master_id_t            bus_owner_q, bus_owner_d;
    master_id_t            split_owner_q, split_owner_d;
    logic [SLAVE_LEN-1:0]  cand_sel_q, cand_sel_d;
    logic [SLAVE_LEN-1:0]  bus_sel_q, bus_sel_d;
    logic [SLAVE_LEN-1:0]  split_sel_q, split_sel_d;
    logic                  cand_resume_q, cand_resume_d;
    logic                  split_pending_q, split_pending_d;
    logic                  sel_err_q, sel_err_d;
    logic [1:0]            err_seen_q, err_seen_d;
    logic [NUM_SLAVES-1:0] split_en_prev_q, split_en_prev_d;

    logic m1_inv, m2_inv, m1_ok, m2_ok, resume_ok, split_rise, m1_wins_tie;
    logic wd_expire, timeout_c;

    assign m1_inv = m1_req && (m1_slave_sel == SEL_INV);
    assign m2_inv = m2_req && (m2_slave_sel == SEL_INV);

    // A parked split blocks both its slave and its master until resume.
    assign m1_ok = m1_req && !m1_inv &&
                   !(split_pending_q && ((m1_slave_sel == split_sel_q) || (split_owner_q == M1)));
    assign m2_ok = m2_req && !m2_inv &&
                   !(split_pending_q && ((m2_slave_sel == split_sel_q) || (split_owner_q == M2)));

    assign resume_ok  = split_pending_q && !s_split_en[split_sel_q];
    assign split_rise = s_split_en[bus_sel_q] && !split_en_prev_q[bus_sel_q];
    assign split_en_prev_d = s_split_en;

`ifdef ARB_ROUND_ROBIN_EN
    master_id_t last_owner_q, last_owner_d;

    assign last_owner_d = (state_q == ARB) ? cand_owner_q : last_owner_q;
    assign m1_wins_tie  = (last_owner_q == M2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= M2;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    assign m1_wins_tie = 1'b1;
`endif

    always_comb begin
        state_d         = state_q;
        cand_owner_d    = cand_owner_q;
        cand_sel_d      = cand_sel_q;
        cand_resume_d   = cand_resume_q;
        bus_owner_d     = bus_owner_q;
        bus_sel_d       = bus_sel_q;
        split_owner_d   = split_owner_q;
        split_sel_d     = split_sel_q;
        split_pending_d = split_pending_q;
        timeout_c       = 1'b0;
        err_seen_d      = {m2_inv, m1_inv};
        sel_err_d       = (m1_inv && !err_seen_q[0]) || (m2_inv && !err_seen_q[1]);

        case (state_q)
            IDLE: begin
                if (resume_ok) begin
                    state_d       = ARB;
                    cand_owner_d  = split_owner_q;
                    cand_sel_d    = split_sel_q;
                    cand_resume_d = 1'b1;
                end else if (m1_ok && (!m2_ok || m1_wins_tie)) begin
                    state_d       = ARB;
                    cand_owner_d  = M1;
                    cand_sel_d    = m1_slave_sel;
                    cand_resume_d = 1'b0;
                end else if (m2_ok) begin
                    state_d       = ARB;
                    cand_owner_d  = M2;
                    cand_sel_d    = m2_slave_sel;
                    cand_resume_d = 1'b0;
                end
            end
            ARB: begin
                state_d     = OWNED;
                bus_owner_d = cand_owner_q;
                bus_sel_d   = cand_sel_q;
                if (cand_resume_q) begin
                    split_pending_d = 1'b0;
                end
            end
            OWNED: begin
                if (tx_done) begin
                    state_d = IDLE;
                end else if (split_rise && !split_pending_q) begin
                    state_d         = IDLE;
                    split_pending_d = 1'b1;
                    split_owner_d   = bus_owner_q;
                    split_sel_d     = bus_sel_q;
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    timeout_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            cand_owner_q    <= M1;
            cand_sel_q      <= '0;
            cand_resume_q   <= 1'b0;
            bus_owner_q     <= M1;
            bus_sel_q       <= '0;
            split_owner_q   <= M1;
            split_sel_q     <= '0;
            split_pending_q <= 1'b0;
            sel_err_q       <= 1'b0;
            err_seen_q      <= '0;
            split_en_prev_q <= '0;
        end else begin
            state_q         <= state_d;
            cand_owner_q    <= cand_owner_d;
            cand_sel_q      <= cand_sel_d;
            cand_resume_q   <= cand_resume_d;
            bus_owner_q     <= bus_owner_d;
            bus_sel_q       <= bus_sel_d;
            split_owner_q   <= split_owner_d;
            split_sel_q     <= split_sel_d;
            split_pending_q <= split_pending_d;
            sel_err_q       <= sel_err_d;
            err_seen_q      <= err_seen_d;
            split_en_prev_q <= split_en_prev_d;
        end
    end

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != OWNED),
        .en     (state_q == OWNED),
        .expire (wd_expire)
    );

    assign m1_grant      = (state_q == OWNED) && (bus_owner_q == M1);
    assign m2_grant      = (state_q == OWNED) && (bus_owner_q == M2);
    assign arb_busy      = (state_q == ARB);
    assign bus_busy      = (state_q == OWNED);
    assign bus_owner     = bus_owner_q;
    assign bus_sel       = bus_sel_q;
    assign split_pending = split_pending_q;
    assign sel_err       = sel_err_q;
    assign timeout       = timeout_c;

endmodule

// File: tb/tb_split_arbiter.sv
// Directed bench for split_arbiter with TIMEOUT_CYCLES=4.
module tb_split_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m1_req = 1'b0, m2_req = 1'b0;
    logic [1:0] m1_slave_sel = 2'd0, m2_slave_sel = 2'd0;
    logic       tx_done = 1'b0;
    logic [2:0] s_split_en = 3'b000;
    logic       m1_grant, m2_grant, arb_busy, bus_busy, bus_owner;
    logic [1:0] bus_sel;
    logic       split_pending, sel_err, timeout;
    logic [6:0] st;

    int vec  = 0;
    int miss = 0;

    split_arbiter #(
        .SLAVE_LEN(2), .NUM_SLAVES(3), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m1_req(m1_req), .m2_req(m2_req),
        .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
        .tx_done(tx_done), .s_split_en(s_split_en),
        .m1_grant(m1_grant), .m2_grant(m2_grant),
        .arb_busy(arb_busy), .bus_busy(bus_busy),
        .bus_owner(bus_owner), .bus_sel(bus_sel),
        .split_pending(split_pending), .sel_err(sel_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // {m1_grant, m2_grant, arb_busy, bus_busy, split_pending, sel_err, timeout}
    assign st = {m1_grant, m2_grant, arb_busy, bus_busy, split_pending, sel_err, timeout};

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Entered in an IDLE cycle with the winner's request already driven.
    task automatic serve(input string tag, input logic m2win, input logic [1:0] sel_e,
                         input logic sp_arb, input logic sp_own);
        logic [6:0] g;
        g = m2win ? 7'b0101000 : 7'b1001000;
        nxt(); #1;
        chk({tag, "_arb"}, st, {1'b0, 7'b0010000 | {4'b0, sp_arb, 2'b0}});
        nxt();
        if (m2win) m2_req = 1'b0; else m1_req = 1'b0;
        tx_done = 1'b1;
        #1;
        chk({tag, "_own"}, st, {1'b0, g | {4'b0, sp_own, 2'b0}});
        chk({tag, "_owner"}, bus_owner, m2win);
        chk({tag, "_sel"}, bus_sel, sel_e);
        nxt();
        tx_done = 1'b0;
        #1;
        chk({tag, "_idle"}, st, {5'b0, sp_own, 2'b0});
        chk({tag, "_hold"}, bus_sel, sel_e);
    endtask

    initial begin
        #3;
        chk("rst_st", st, 8'd0);
        chk("rst_owner", bus_owner, 8'd0);
        chk("rst_sel", bus_sel, 8'd0);
        @(posedge clk); #2;
        rst = 1'b1;

        // Tie from reset: M1 first, then M2.
        m1_req = 1'b1; m1_slave_sel = 2'd1;
        m2_req = 1'b1; m2_slave_sel = 2'd0;
        serve("tie1_m1", 1'b0, 2'd1, 1'b0, 1'b0);
        serve("tie1_m2", 1'b1, 2'd0, 1'b0, 1'b0);

        // Uncontended M1 request: latency and release.
        m1_req = 1'b1; m1_slave_sel = 2'd0;
        serve("lat", 1'b0, 2'd0, 1'b0, 1'b0);

        // Second tie, M1 owned last.
        m1_req = 1'b1; m1_slave_sel = 2'd0;
        m2_req = 1'b1; m2_slave_sel = 2'd1;
`ifdef ARB_ROUND_ROBIN_EN
        serve("tie2_m2", 1'b1, 2'd1, 1'b0, 1'b0);
        serve("tie2_m1", 1'b0, 2'd0, 1'b0, 1'b0);
`else
        serve("tie2_m1", 1'b0, 2'd0, 1'b0, 1'b0);
        serve("tie2_m2", 1'b1, 2'd1, 1'b0, 1'b0);
`endif

        // tx_done and split rise together: tx_done wins.
        m1_req = 1'b1; m1_slave_sel = 2'd2;
        nxt(); #1; chk("txs_arb", st, 8'b0010000);
        nxt(); m1_req = 1'b0; tx_done = 1'b1; s_split_en = 3'b100; #1;
        chk("txs_own", st, 8'b1001000);
        nxt(); tx_done = 1'b0; #1;
        chk("txs_idle", st, 8'b0000000);
        s_split_en = 3'b000;
        nxt();

        // M1 owns slave 3, slave splits.
        m1_req = 1'b1; m1_slave_sel = 2'd2;
        nxt(); #1; chk("sp_arb", st, 8'b0010000);
        nxt(); m1_req = 1'b0; s_split_en = 3'b100; #1;
        chk("sp_own", st, 8'b1001000);
        chk("sp_sel", bus_sel, 8'd2);
        nxt(); #1;
        chk("sp_park", st, 8'b0000100);

        // M2 may use another slave while parked.
        m2_req = 1'b1; m2_slave_sel = 2'd1;
        serve("sp_m2", 1'b1, 2'd1, 1'b1, 1'b1);

        // M2 to the split slave is blocked.
        m2_req = 1'b1; m2_slave_sel = 2'd2;
        nxt(); #1; chk("blk_a", st, 8'b0000100);
        nxt(); #1; chk("blk_b", st, 8'b0000100);

        // M2 owns slave 2; split slave recovers meanwhile; M2 keeps requesting.
        m2_slave_sel = 2'd1;
        nxt(); #1; chk("rec_arb", st, 8'b0010100);
        nxt(); s_split_en = 3'b000; tx_done = 1'b1; #1;
        chk("rec_own", st, 8'b0101100);
        chk("rec_sel", bus_sel, 8'd1);
        nxt(); tx_done = 1'b0; #1;
        chk("rec_idle", st, 8'b0000100);
        serve("resume", 1'b0, 2'd2, 1'b1, 1'b0);
        serve("m2_after", 1'b1, 2'd1, 1'b0, 1'b0);

        // Invalid select: one sel_err pulse, no grant.
        m2_req = 1'b1; m2_slave_sel = 2'd3;
        nxt(); #1; chk("selerr_pulse", st, 8'b0000010);
        nxt(); #1; chk("selerr_once", st, 8'b0000000);
        nxt(); #1; chk("selerr_nogrant", st, 8'b0000000);
        m2_req = 1'b0; m2_slave_sel = 2'd0;
        nxt();

        // Watchdog: timeout in the 4th owned cycle.
        m1_req = 1'b1; m1_slave_sel = 2'd0;
        nxt(); #1; chk("wd_arb", st, 8'b0010000);
        nxt(); m1_req = 1'b0; #1; chk("wd_c1", st, 8'b1001000);
        nxt(); #1; chk("wd_c2", st, 8'b1001000);
        nxt(); #1; chk("wd_c3", st, 8'b1001000);
        nxt(); #1; chk("wd_c4", st, 8'b1001001);
        nxt(); #1; chk("wd_rel", st, 8'b0000000);

        // Reset while M2 owns slave 2.
        m2_req = 1'b1; m2_slave_sel = 2'd1;
        nxt(); nxt(); m2_req = 1'b0; #1;
        chk("mr_own", st, 8'b0101000);
        chk("mr_owner", bus_owner, 8'd1);
        #1 rst = 1'b0;
        #1;
        chk("mr_st", st, 8'd0);
        chk("mr_owner0", bus_owner, 8'd0);
        chk("mr_sel0", bus_sel, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
